// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and defaults for the i2c request arbiter: FSM encoding,
// counter width and a saturating increment used by the wait/timeout counter.
package i2c_req_arbiter_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_BUSY_WAIT   = 16;
    localparam int DEF_TIMEOUT_CYC = 65535;
    localparam int CNT_W           = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_BSY = 3'd2,
        ST_RUN      = 3'd3,
        ST_RESP     = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr.sv
// Combinational round-robin picker: scans from i_ptr+1 upward with wrap and
// returns the first pending request as a one-hot grant plus its index.
module i2c_req_arbiter_rr #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_pos = IDX_W'((int'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one i2c_master read engine between N_REQ clients: round-robin grant,
// start strobe, busy/data_valid tracking with busy-wait and run watchdogs.
module i2c_req_arbiter
    import i2c_req_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BUSY_WAIT   = DEF_BUSY_WAIT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  done,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic [N_REQ-1:0]  grant,
    output logic              m_start,
    input  logic              m_busy,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_data_valid
);

    // state    | meaning
    // IDLE     | no owner; pick next requester once the master is free
    // ISSUE    | m_start high for this cycle only
    // WAIT_BSY | waiting for the master to raise busy
    // RUN      | master busy; wait for data_valid, abort or timeout
    // RESP     | done/rsp_err/rsp_data valid for this cycle
    // DRAIN    | wait for busy to fall before arbitrating again

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_WAIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [N_REQ-1:0]  r_req;
    logic [N_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_REQ-1:0]  r_done;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_m_start;

    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_valid;

    i2c_req_arbiter_rr #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (r_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_grant    <= '0;
            r_idx      <= '0;
            r_ptr      <= IDX_W'(N_REQ - 1);
            r_cnt      <= '0;
            r_done     <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
            r_m_start  <= 1'b0;
        end else begin
            r_req      <= req;
            r_m_start  <= 1'b0;
            r_done     <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_data <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid && !m_busy) begin
                        r_grant   <= w_grant;
                        r_idx     <= w_idx;
                        r_m_start <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT_BSY;
                end
                ST_WAIT_BSY: begin
                    if (m_busy) begin
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else if (r_cnt == BUSY_LAST) begin
                        r_done    <= r_grant;
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_RUN: begin
                    // data_valid wins even if busy falls in the same cycle
                    if (m_data_valid) begin
                        r_done     <= r_grant;
                        r_rsp_data <= m_data;
                        r_state    <= ST_RESP;
                    end else if (!m_busy || r_cnt == TO_LAST) begin
                        r_done    <= r_grant;
                        r_rsp_err <= 1'b1;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                ST_RESP: begin
                    r_ptr   <= r_idx;
                    r_grant <= '0;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!m_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done     = r_done;
    assign rsp_err  = r_rsp_err;
    assign rsp_data = r_rsp_data;
    assign grant    = r_grant;
    assign m_start  = r_m_start;

endmodule
